loan_io_arbiter: RTL and testbench

- Shares the HPS loan-IO pin group (h2f_loan_io_out/oe/in, 67 bits) between several FPGA-side requesters, e.g. a bit-banged SPI engine and a debug GPIO driver.
- Grants exclusive ownership round-robin and enforces a per-owner hold limit.
- Inserts an all-oe-low turnaround gap between owners so two drivers never overlap.
- Sits between the Computer_System loan-IO conduit and the receiver's peripheral logic.

---
 rtl/loan_io_pkg.sv | 8 +
 rtl/loan_io_arbiter_rr_picker.sv | 26 ++
 rtl/loan_io_arbiter.sv | 132 +++++++++++++
 tb/tb_loan_io_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loan_io_pkg.sv
// loan_io_pkg: shared constants and types for the loan-IO arbiter
package loan_io_pkg;
    localparam int LOAN_W = 67;
    localparam logic [LOAN_W-1:0] LOAN_PINS_HPS = (LOAN_W'(1) << 49) | (LOAN_W'(1) << 50)
                                                | (LOAN_W'(1) << 53) | (LOAN_W'(1) << 54);
    localparam int OWNER_W = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;
endpackage

// File: rtl/loan_io_arbiter_rr_picker.sv
// rr_picker: first eligible index strictly after the last winner, wrapping modulo N
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = loan_io_pkg::OWNER_W
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);
    int w_best;
    // keep the eligible index with the smallest rotational distance from i_last+1
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_best  = N;
        for (int k = 0; k < N; k++)
            if (i_elig[k] && ((k + 2 * N - 1 - int'(i_last)) % N) < w_best) begin
                w_best  = (k + 2 * N - 1 - int'(i_last)) % N;
                o_idx   = IW'(k);
                o_valid = 1'b1;
            end
        o_onehot = o_valid ? (N'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/loan_io_arbiter.sv
// loan_io_arbiter: round-robin owner of the HPS loan-IO pins with hold limit and oe-low turnaround; LOAN_IO_IN_SYNC_EN adds a 2-flop input synchronizer
module loan_io_arbiter #(
    parameter int                NUM_REQ    = 4,
    parameter int                LOAN_W     = loan_io_pkg::LOAN_W,
    parameter logic [LOAN_W-1:0] PIN_MASK   = loan_io_pkg::LOAN_PINS_HPS,
    parameter int                TURNAROUND = 2,
    parameter int                MAX_HOLD   = 1024
) (
    input  logic                      system_clk_clk,
    input  logic                      system_reset_reset,
    input  logic [NUM_REQ-1:0]        req_i,
    output logic [NUM_REQ-1:0]        grant_o,
    input  logic [NUM_REQ*LOAN_W-1:0] req_out_i,
    input  logic [NUM_REQ*LOAN_W-1:0] req_oe_i,
    output logic [LOAN_W-1:0]         loan_in_o,
    output logic [LOAN_W-1:0]         h2f_loan_io_out,
    output logic [LOAN_W-1:0]         h2f_loan_io_oe,
    input  logic [LOAN_W-1:0]         h2f_loan_io_in,
    output logic                      busy_o,
    output logic [2:0]                owner_o,
    output logic                      timeout_o
);
    import loan_io_pkg::*;
    localparam int HW = $clog2(MAX_HOLD);
    localparam int TW = $clog2(TURNAROUND + 1);
    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_block;
    logic [OWNER_W-1:0]   r_owner;
    logic [OWNER_W-1:0]   r_rr_last;
    logic [HW-1:0]        r_hold;
    logic [TW-1:0]        r_turn;
    logic                 r_timeout;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [OWNER_W-1:0]   w_pick_idx;
    logic                 w_pick_vld;
    logic                 w_own_req;
    logic                 w_limit;
    logic [LOAN_W-1:0]    w_own_out;
    logic [LOAN_W-1:0]    w_own_oe;

    rr_picker #(.N(NUM_REQ), .IW(OWNER_W)) u_pick (
        .i_elig   (req_i & ~r_block),
        .i_last   (r_rr_last),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_vld)
    );

    assign w_own_req = |(req_i & r_grant);
    assign w_limit   = r_hold == HW'(MAX_HOLD - 1);

    // pin mux driven by the grant register, so pins go quiet the instant grant clears
    always_comb begin
        w_own_out = '0;
        w_own_oe  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_own_out = w_own_out | (req_out_i[k*LOAN_W +: LOAN_W] & {LOAN_W{r_grant[k]}});
            w_own_oe  = w_own_oe  | (req_oe_i[k*LOAN_W +: LOAN_W]  & {LOAN_W{r_grant[k]}});
        end
    end

    assign h2f_loan_io_out = w_own_out & PIN_MASK;
    assign h2f_loan_io_oe  = w_own_oe & PIN_MASK;
    assign grant_o         = r_grant;
    assign owner_o         = r_owner;
    assign busy_o          = r_state != ST_IDLE;
    assign timeout_o       = r_timeout;

    // arbitration FSM; the IDLE arbitration cycle is the last cycle of the oe-low gap
    always_ff @(posedge system_clk_clk or posedge system_reset_reset) begin
        if (system_reset_reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_block   <= '0;
            r_owner   <= '0;
            r_rr_last <= OWNER_W'(NUM_REQ - 1);
            r_hold    <= '0;
            r_turn    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_block   <= r_block & req_i;
            case (r_state)
                ST_IDLE: if (w_pick_vld) begin
                    r_state   <= ST_GRANT;
                    r_grant   <= w_pick_oh;
                    r_owner   <= w_pick_idx;
                    r_rr_last <= w_pick_idx;
                    r_hold    <= '0;
                end
                ST_GRANT: begin
                    r_hold <= r_hold + 1'b1;
                    if (!w_own_req || w_limit) begin
                        r_grant <= '0;
                        r_turn  <= '0;
                        r_state <= (TURNAROUND > 1) ? ST_TURN : ST_IDLE;
                        if (w_own_req) begin
                            r_timeout <= 1'b1;
                            r_block   <= (r_block | r_grant) & req_i;
                        end
                    end
                end
                ST_TURN: begin
                    if (r_turn == TW'(TURNAROUND - 2))
                        r_state <= ST_IDLE;
                    else
                        r_turn <= r_turn + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef LOAN_IO_IN_SYNC_EN
    logic [LOAN_W-1:0] r_in_s1;
    logic [LOAN_W-1:0] r_in_s2;
    // two-flop synchronizer on the loan-IO input bus
    always_ff @(posedge system_clk_clk or posedge system_reset_reset) begin
        if (system_reset_reset) begin
            r_in_s1 <= '0;
            r_in_s2 <= '0;
        end else begin
            r_in_s1 <= h2f_loan_io_in;
            r_in_s2 <= r_in_s1;
        end
    end
    assign loan_in_o = r_in_s2;
`else
    assign loan_in_o = h2f_loan_io_in;
`endif
endmodule

// File: tb/tb_loan_io_arbiter.sv
// tb_loan_io_arbiter: randomized checks of loan_io_arbiter against an ownership/gap model
module tb_loan_io_arbiter;
    localparam int N  = 4;
    localparam int W  = 67;
    localparam int TA = 2;
    localparam int MH = 8;
    localparam int VW = N + 2 * W + 5;
    localparam logic [W-1:0] MASK = (W'(1) << 49) | (W'(1) << 50) | (W'(1) << 53) | (W'(1) << 54);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   grant;
    logic [N*W-1:0] rout = '0;
    logic [N*W-1:0] roe = '0;
    logic [W-1:0]   lin, hout, hoe;
    logic [W-1:0]   hin = '0;
    logic           busy, tmo;
    logic [2:0]     owner;
    int n_chk = 0;
    int n_fail = 0;

    int           m_owner, m_last, m_held, m_gap, m_prev;
    logic [N-1:0] m_block;
    logic         m_tmo;

    loan_io_arbiter #(.NUM_REQ(N), .LOAN_W(W), .PIN_MASK(MASK), .TURNAROUND(TA), .MAX_HOLD(MH)) dut (
        .system_clk_clk     (clk),
        .system_reset_reset (rst),
        .req_i              (req),
        .grant_o            (grant),
        .req_out_i          (rout),
        .req_oe_i           (roe),
        .loan_in_o          (lin),
        .h2f_loan_io_out    (hout),
        .h2f_loan_io_oe     (hoe),
        .h2f_loan_io_in     (hin),
        .busy_o             (busy),
        .owner_o            (owner),
        .timeout_o          (tmo)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;
        m_gap   = TA;
        m_prev  = 0;
        m_block = '0;
        m_tmo   = 1'b0;
    endtask

    // one clock edge of the reference: owners hold, release into a TA-cycle gap, then round-robin
    task automatic tick();
        @(posedge clk);
        m_tmo = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (!req[m_owner]) begin
                m_owner = -1;
                m_gap   = 1;
            end else if (m_held == MH) begin
                m_block[m_owner] = 1'b1;
                m_tmo   = 1'b1;
                m_owner = -1;
                m_gap   = 1;
            end
        end else if (m_gap >= TA && |(req & ~m_block)) begin
            for (int i = 1; i <= N; i++)
                if (m_owner < 0 && req[(m_last + i) % N] && !m_block[(m_last + i) % N])
                    m_owner = (m_last + i) % N;
            m_last = m_owner;
            m_prev = m_owner;
            m_held = 0;
        end else begin
            m_gap++;
        end
        m_block = m_block & req;
        #1;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g = '0;
        logic [W-1:0] o = '0;
        logic [W-1:0] e = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            o = W'(rout >> (m_owner * W)) & MASK;
            e = W'(roe >> (m_owner * W)) & MASK;
        end
        return {g, o, e, m_tmo, (m_owner >= 0 || m_gap < TA), 3'(m_prev)};
    endfunction

    task automatic rand_bus();
        for (int i = 0; i < N * W; i++) begin
            rout[i] = 1'($urandom_range(0, 1));
            roe[i]  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        hin = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        #1;
        n_chk++;
        if ({grant, hout, hoe, busy, owner, tmo} !== '0) begin
            n_fail++;
            $display("FAIL reset: got grant=%b oe=%h busy=%b owner=%0d tmo=%b, want all zero", grant, hoe, busy, owner, tmo);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        rand_bus();
        roe[W-1:0] = '1;
        req = 4'b0001;
        tick();
        n_chk++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: got %b want 0001", grant);
        end
        n_chk++;
        if (hoe !== MASK) begin
            n_fail++;
            $display("FAIL single_oe: got %h want %h", hoe, MASK);
        end
        for (int c = 0; c < 6; c++) begin
            rand_bus();
            req = (c < 3) ? 4'b0001 : 4'b0000;
            tick();
            n_chk++;
            if ({grant, hout, hoe, tmo, busy, owner} !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_cycle%0d: got %h want %h", c, {grant, hout, hoe, tmo, busy, owner}, exp_vec());
            end
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int gaps[$];
        int gap = 0;
        logic [N-1:0] prev = '0;
        apply_reset();
        req = '1;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            rand_bus();
            req = '1;
            if (m_owner >= 0 && m_held == 4) req[m_owner] = 1'b0;
            tick();
            n_chk++;
            if ({grant, hout, hoe, tmo, busy, owner} !== exp_vec()) begin
                n_fail++;
                $display("FAIL rotation_cycle%0d: got %h want %h", c, {grant, hout, hoe, tmo, busy, owner}, exp_vec());
            end
            if (grant != '0 && prev == '0) begin
                for (int k = 0; k < N; k++) if (grant[k]) order.push_back(k);
                gaps.push_back(gap);
            end
            gap  = (grant == '0) ? gap + 1 : 0;
            prev = grant;
        end
        n_chk++;
        if (order.size() != 5) begin
            n_fail++;
            $display("FAIL rotation_count: got %0d grants want 5", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            n_chk++;
            if (order[i] != i % N) begin
                n_fail++;
                $display("FAIL rotation_order%0d: got %0d want %0d", i, order[i], i % N);
            end
            if (i > 0) begin
                n_chk++;
                if (gaps[i] != TA) begin
                    n_fail++;
                    $display("FAIL rotation_gap%0d: got %0d want %0d", i, gaps[i], TA);
                end
            end
        end
    endtask

    task automatic test_hold_limit();
        int held = 0;
        int pulses = 0;
        bit regrant = 1'b0;
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            rand_bus();
            req = 4'b0100;
            tick();
            n_chk++;
            if ({grant, hout, hoe, tmo, busy, owner} !== exp_vec()) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got %h want %h", c, {grant, hout, hoe, tmo, busy, owner}, exp_vec());
            end
            held   += (grant == 4'b0100) ? 1 : 0;
            pulses += tmo ? 1 : 0;
        end
        n_chk++;
        if (held != MH) begin
            n_fail++;
            $display("FAIL hold_cycles: got %0d want %0d", held, MH);
        end
        n_chk++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL hold_timeout_pulses: got %0d want 1", pulses);
        end
        req = 4'b0000;
        tick();
        req = 4'b0100;
        for (int c = 0; c < 6 && !regrant; c++) begin
            tick();
            regrant = grant == 4'b0100;
        end
        n_chk++;
        if (!regrant) begin
            n_fail++;
            $display("FAIL hold_regrant: got grant=%b want 0100 within 6 cycles", grant);
        end
    endtask

    task automatic test_simultaneous_release();
        bit seen_tmo = 1'b0;
        apply_reset();
        req = 4'b0010;
        for (int c = 0; c < 20 && !(m_owner == 1 && m_held == MH - 1); c++) tick();
        n_chk++;
        if (!(m_owner == 1 && m_held == MH - 1) || grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL simul_reach_limit: got grant=%b want 0010 at last hold cycle", grant);
        end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen_tmo |= tmo;
            n_chk++;
            if ({grant, hout, hoe, tmo, busy, owner} !== exp_vec()) begin
                n_fail++;
                $display("FAIL simul_cycle%0d: got %h want %h", c, {grant, hout, hoe, tmo, busy, owner}, exp_vec());
            end
        end
        n_chk++;
        if (seen_tmo) begin
            n_fail++;
            $display("FAIL simul_timeout: got timeout pulse want none");
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        rand_bus();
        roe[W-1:0] = '1;
        req = 4'b0001;
        tick();
        tick();
        n_chk++;
        if (hoe !== MASK) begin
            n_fail++;
            $display("FAIL areset_pre_oe: got %h want %h", hoe, MASK);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({grant, hoe, busy} !== '0) begin
            n_fail++;
            $display("FAIL areset_immediate: got grant=%b oe=%h busy=%b want 0", grant, hoe, busy);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_chk++;
        if ({grant, hout, hoe, tmo, busy, owner} !== exp_vec()) begin
            n_fail++;
            $display("FAIL areset_regrant: got %h want %h", {grant, hout, hoe, tmo, busy, owner}, exp_vec());
        end
    endtask

    task automatic test_loan_in();
        logic [W-1:0] prev = '0;
        apply_reset();
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            hin = W'({$urandom, $urandom, $urandom});
            hin[49] = c[0];
`ifdef LOAN_IO_IN_SYNC_EN
            tick();
            n_chk++;
            if (lin !== prev) begin
                n_fail++;
                $display("FAIL loan_in_sync%0d: got %h want %h", c, lin, prev);
            end
            prev = hin;
`else
            #1;
            n_chk++;
            if (lin !== hin) begin
                n_fail++;
                $display("FAIL loan_in_comb%0d: got %h want %h", c, lin, hin);
            end
            prev = hin;
            tick();
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_hold_limit();
        test_simultaneous_release();
        test_async_reset();
        test_loan_in();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
